// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the CR16-subset core.
// Steps fetch/decode/execute/mem/writeback and owns the shared memory port.
module cpu_control_fsm #(
  parameter int PC_SEL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic [1:0]          inst_type,
  input  logic [3:0]          cond,
  input  logic                pc_disp_abs,
  input  logic                update_flags,
  input  logic                update_regfile,
  input  logic [4:0]          flags,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_addr_sel,
  output logic                mem_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                regfile_we,
  output logic                wb_sel,
  output logic                flags_we,
  output logic                inst_retired,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [PC_SEL_W-1:0] SEL_INC = PC_SEL_W'(0);
  localparam logic [PC_SEL_W-1:0] SEL_REL = PC_SEL_W'(1);
  localparam logic [PC_SEL_W-1:0] SEL_ABS = PC_SEL_W'(2);

  state_t cur, nxt;
  logic   fetch_busy, fetch_busy_nxt;
  logic   f_n, f_z, f_f, f_l, f_c;
  logic   taken;
  logic   is_load, is_store;

  assign {f_n, f_z, f_f, f_l, f_c} = flags;
  assign is_load  = (inst_type == 2'd1);
  assign is_store = (inst_type == 2'd2);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      4'd0:  taken = f_z;
      4'd1:  taken = !f_z;
      4'd2:  taken = f_c;
      4'd3:  taken = !f_c;
      4'd4:  taken = f_l;
      4'd5:  taken = !f_l;
      4'd6:  taken = f_n;
      4'd7:  taken = !f_n;
      4'd8:  taken = f_f;
      4'd9:  taken = !f_f;
      4'd10: taken = !f_l && !f_z;
      4'd11: taken = f_l || f_z;
      4'd12: taken = !f_n && !f_z;
      4'd13: taken = f_n || f_z;
      4'd14: taken = 1'b1;
      4'd15: taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt            = cur;
    fetch_busy_nxt = fetch_busy;
    mem_req        = 1'b0;
    mem_addr_sel   = 1'b0;
    mem_we         = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = SEL_INC;
    regfile_we     = 1'b0;
    wb_sel         = 1'b0;
    flags_we       = 1'b0;
    inst_retired   = 1'b0;
    unique case (cur)
      S_FETCH: begin
        // halt only wins before the request goes out
        if (!fetch_busy && halt) begin
          nxt = S_HALT;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we          = 1'b1;
            nxt            = S_DECODE;
            fetch_busy_nxt = 1'b0;
          end else begin
            fetch_busy_nxt = 1'b1;
          end
        end
      end
      S_DECODE: begin
        nxt = (is_load || is_store) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        regfile_we   = update_regfile;
        flags_we     = update_flags;
        pc_we        = 1'b1;
        pc_sel       = !taken ? SEL_INC :
                       (pc_disp_abs ? SEL_ABS : SEL_REL);
        inst_retired = 1'b1;
        nxt          = S_FETCH;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we        = 1'b1;
            inst_retired = 1'b1;
            nxt          = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        regfile_we   = 1'b1;
        wb_sel       = 1'b1;
        pc_we        = 1'b1;
        inst_retired = 1'b1;
        nxt          = S_FETCH;
      end
      S_HALT: begin
        if (!halt) nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    // reset aborts any access in flight and silences every strobe
    if (reset) begin
      nxt            = S_FETCH;
      fetch_busy_nxt = 1'b0;
      mem_req        = 1'b0;
      mem_addr_sel   = 1'b0;
      mem_we         = 1'b0;
      ir_we          = 1'b0;
      pc_we          = 1'b0;
      pc_sel         = SEL_INC;
      regfile_we     = 1'b0;
      wb_sel         = 1'b0;
      flags_we       = 1'b0;
      inst_retired   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= S_FETCH;
      fetch_busy <= 1'b0;
    end else begin
      cur        <= nxt;
      fetch_busy <= fetch_busy_nxt;
    end
  end

  assign state = reset ? 3'd0 : cur;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed vector table, corner sequences,
// and random instructions checked against a per-instruction trace model.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset, halt;
  logic [1:0] inst_type;
  logic [3:0] cond;
  logic       pc_disp_abs, update_flags, update_regfile;
  logic [4:0] flags;
  logic       mem_ready;
  logic       mem_req, mem_addr_sel, mem_we, ir_we, pc_we;
  logic [1:0] pc_sel;
  logic       regfile_we, wb_sel, flags_we, inst_retired;
  logic [2:0] state;

  cpu_control_fsm #(.PC_SEL_W(2)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .inst_type(inst_type), .cond(cond),
    .pc_disp_abs(pc_disp_abs), .update_flags(update_flags),
    .update_regfile(update_regfile), .flags(flags),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_addr_sel(mem_addr_sel), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .regfile_we(regfile_we), .wb_sel(wb_sel),
    .flags_we(flags_we), .inst_retired(inst_retired),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr;
    logic       asel;
    logic       we;
    logic       ir;
    logic       pw;
    logic [1:0] sel;
    logic       rf;
    logic       wb;
    logic       fl;
    logic       rt;
    logic [2:0] st;
  } out_t;

  typedef struct packed {
    logic rdy;
    out_t o;
  } step_t;

  typedef struct {
    logic [1:0] itype;
    logic [3:0] cnd;
    logic       abs;
    logic       uf;
    logic       ur;
    logic [4:0] flg;
    logic [1:0] sel;
    int         cyc;
    logic       rf;
    logic       fl;
  } vec_t;

  int    nchk = 0;
  int    nfail = 0;
  step_t trace_q[$];
  vec_t  vt[13];

  function automatic out_t mk(
    input logic mr, asel, we, ir, pw,
    input logic [1:0] sel,
    input logic rf, wb, fl, rt,
    input logic [2:0] st);
    out_t o;
    o = '{mr, asel, we, ir, pw, sel, rf, wb, fl, rt, st};
    return o;
  endfunction

  function automatic logic cond_taken(
    input logic [3:0] c, input logic [4:0] f);
    logic n, z, ff, l, cy;
    logic t[0:15];
    {n, z, ff, l, cy} = f;
    t = '{z, !z, cy, !cy, l, !l, n, !n, ff, !ff,
          !l && !z, l || z, !n && !z, n || z, 1'b1, 1'b0};
    return t[c];
  endfunction

  // Expected per-cycle behaviour of one instruction, from the stated
  // cycle plan; fw/mw are the wait cycles before mem_ready.
  function automatic void build(
    input logic [1:0] it, input logic [3:0] c,
    input logic abs, uf, ur, input logic [4:0] f,
    input int fw, mw);
    logic [1:0] sel;
    logic       st_op;
    for (int i = 0; i < fw; i++)
      trace_q.push_back('{1'b0, mk(1,0,0,0,0,0,0,0,0,0,3'd0)});
    trace_q.push_back('{1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0)});
    trace_q.push_back('{1'($urandom_range(0,1)),
                        mk(0,0,0,0,0,0,0,0,0,0,3'd1)});
    if (it == 2'd1 || it == 2'd2) begin
      st_op = (it == 2'd2);
      for (int i = 0; i < mw; i++)
        trace_q.push_back('{1'b0, mk(1,1,st_op,0,0,0,0,0,0,0,3'd3)});
      if (st_op) begin
        trace_q.push_back('{1'b1, mk(1,1,1,0,1,0,0,0,0,1,3'd3)});
      end else begin
        trace_q.push_back('{1'b1, mk(1,1,0,0,0,0,0,0,0,0,3'd3)});
        trace_q.push_back('{1'($urandom_range(0,1)),
                            mk(0,0,0,0,1,0,1,1,0,1,3'd4)});
      end
    end else begin
      sel = !cond_taken(c, f) ? 2'd0 : (abs ? 2'd2 : 2'd1);
      trace_q.push_back('{1'($urandom_range(0,1)),
                          mk(0,0,0,0,1,sel,ur,0,uf,1,3'd2)});
    end
  endfunction

  task automatic set_inst(
    input logic [1:0] it, input logic [3:0] c,
    input logic abs, uf, ur, input logic [4:0] f);
    inst_type = it; cond = c; pc_disp_abs = abs;
    update_flags = uf; update_regfile = ur; flags = f;
  endtask

  task automatic check_cycle(input out_t exp, input string name);
    out_t act;
    @(negedge clk);
    act = mk(mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_sel,
             regfile_we, wb_sel, flags_we, inst_retired, state);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time,
               act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic play(input string name);
    step_t s;
    while (trace_q.size() > 0) begin
      s = trace_q.pop_front();
      mem_ready = s.rdy;
      check_cycle(s.o, name);
    end
  endtask

  task automatic run_inst(
    input logic [1:0] it, input logic [3:0] c,
    input logic abs, uf, ur, input logic [4:0] f,
    input int fw, mw, input string name);
    set_inst(it, c, abs, uf, ur, f);
    build(it, c, abs, uf, ur, f, fw, mw);
    play(name);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         cyc;
    logic       got;
    logic [1:0] s;
    logic       rf, fl;
    set_inst(v.itype, v.cnd, v.abs, v.uf, v.ur, v.flg);
    mem_ready = 1'b1;
    cyc = 0; got = 1'b0; s = '0; rf = 1'b0; fl = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (inst_retired) begin
        got = 1'b1; s = pc_sel; rf = regfile_we; fl = flags_we;
      end
      @(posedge clk);
      #1;
    end
    nchk += 4;
    if (!got || cyc != v.cyc) begin
      nfail++;
      $display("FAIL vec%0d latency: got %0d cycles (retired=%0b) expected %0d",
               idx, cyc, got, v.cyc);
    end
    if (s !== v.sel) begin
      nfail++;
      $display("FAIL vec%0d pc_sel: got %0d expected %0d", idx, s, v.sel);
    end
    if (rf !== v.rf) begin
      nfail++;
      $display("FAIL vec%0d regfile_we: got %0b expected %0b", idx, rf, v.rf);
    end
    if (fl !== v.fl) begin
      nfail++;
      $display("FAIL vec%0d flags_we: got %0b expected %0b", idx, fl, v.fl);
    end
  endtask

  localparam out_t ZERO = '0;

  initial begin
    //       type  cond   abs uf ur flags     sel  cyc rf fl
    vt[0]  = '{2'd0, 4'd15, 0, 1, 1, 5'b00000, 2'd0, 3, 1, 1};
    vt[1]  = '{2'd0, 4'd0,  0, 0, 0, 5'b01000, 2'd1, 3, 0, 0};
    vt[2]  = '{2'd0, 4'd0,  0, 0, 0, 5'b00000, 2'd0, 3, 0, 0};
    vt[3]  = '{2'd0, 4'd14, 1, 0, 0, 5'b00000, 2'd2, 3, 0, 0};
    vt[4]  = '{2'd0, 4'd10, 0, 0, 0, 5'b00000, 2'd1, 3, 0, 0};
    vt[5]  = '{2'd0, 4'd10, 0, 0, 0, 5'b00010, 2'd0, 3, 0, 0};
    vt[6]  = '{2'd0, 4'd13, 1, 0, 0, 5'b10000, 2'd2, 3, 0, 0};
    vt[7]  = '{2'd0, 4'd12, 0, 0, 0, 5'b10000, 2'd0, 3, 0, 0};
    vt[8]  = '{2'd3, 4'd14, 0, 0, 1, 5'b00000, 2'd1, 3, 1, 0};
    vt[9]  = '{2'd1, 4'd15, 0, 0, 1, 5'b00000, 2'd0, 4, 1, 0};
    vt[10] = '{2'd2, 4'd15, 0, 1, 1, 5'b00000, 2'd0, 3, 0, 0};
    vt[11] = '{2'd0, 4'd2,  0, 0, 0, 5'b00001, 2'd1, 3, 0, 0};
    vt[12] = '{2'd0, 4'd9,  1, 0, 0, 5'b00100, 2'd0, 3, 0, 0};

    reset = 1'b1; halt = 1'b0; mem_ready = 1'b1;
    set_inst(2'd0, 4'd15, 0, 0, 0, 5'b0);
    check_cycle(ZERO, "reset0");
    check_cycle(ZERO, "reset1");
    reset = 1'b0;

    foreach (vt[i]) run_vec(vt[i], i);

    run_inst(2'd1, 4'd15, 0, 0, 1, 5'b0, 0, 2, "load_wait2");
    run_inst(2'd2, 4'd15, 0, 1, 1, 5'b0, 0, 0, "store_zw");
    run_inst(2'd0, 4'd15, 0, 1, 1, 5'b0, 3, 0, "alu_fwait");

    set_inst(2'd0, 4'd15, 0, 0, 0, 5'b0);
    halt = 1'b1; mem_ready = 1'b1;
    check_cycle(ZERO, "halt_entry");
    for (int i = 0; i < 5; i++)
      check_cycle(mk(0,0,0,0,0,0,0,0,0,0,3'd5), "halt_hold");
    halt = 1'b0;
    check_cycle(mk(0,0,0,0,0,0,0,0,0,0,3'd5), "halt_exit");
    mem_ready = 1'b0;
    check_cycle(mk(1,0,0,0,0,0,0,0,0,0,3'd0), "resume_fetch");
    halt = 1'b1;
    check_cycle(mk(1,0,0,0,0,0,0,0,0,0,3'd0), "halt_in_fetch");
    mem_ready = 1'b1;
    check_cycle(mk(1,0,0,1,0,0,0,0,0,0,3'd0), "fetch_done");
    check_cycle(mk(0,0,0,0,0,0,0,0,0,0,3'd1), "decode_after_halt");
    check_cycle(mk(0,0,0,0,1,0,0,0,0,1,3'd2), "exec_after_halt");
    halt = 1'b0;

    set_inst(2'd1, 4'd15, 0, 0, 1, 5'b0);
    mem_ready = 1'b1;
    check_cycle(mk(1,0,0,1,0,0,0,0,0,0,3'd0), "rst_fetch");
    check_cycle(mk(0,0,0,0,0,0,0,0,0,0,3'd1), "rst_decode");
    mem_ready = 1'b0;
    check_cycle(mk(1,1,0,0,0,0,0,0,0,0,3'd3), "rst_mem_stall");
    reset = 1'b1; mem_ready = 1'b1;
    check_cycle(ZERO, "rst_abort");
    reset = 1'b0;
    run_inst(2'd1, 4'd15, 0, 0, 1, 5'b0, 1, 0, "after_reset");

    for (int k = 0; k < 200; k++) begin
      run_inst(2'($urandom_range(0,3)), 4'($urandom_range(0,15)),
               1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
               1'($urandom_range(0,1)), 5'($urandom_range(0,31)),
               int'($urandom_range(0,3)), int'($urandom_range(0,3)),
               "random");
    end

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle sequencer for the CR16-subset core. It consumes the instruction decoder's control outputs and the flag register, and steps the datapath through fetch, decode, execute, memory and writeback. It drives the instruction-register, PC, regfile, flag and memory strobes, and owns the single shared memory port handshake used by both instruction fetch and data access.

## Interface
- `PC_SEL_W`, default 2: width of `pc_sel`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `halt` input 1: request to stop issuing fetches.
- `inst_type` input 2: from decoder. 0 = register/ALU/branch, 1 = load, 2 = store, 3 = treated as 0.
- `cond` input 4: branch condition from decoder. 4'b1111 = never.
- `pc_disp_abs` input 1: taken branch target is absolute (register) when 1, PC + displacement when 0.
- `update_flags` input 1: instruction writes flags.
- `update_regfile` input 1: instruction writes `reg_dst`.
- `flags` input 5: {N, Z, F, L, C} from the flag register.
- `mem_ready` input 1: memory completes the transfer this cycle.
- `mem_req` output 1: memory access request.
- `mem_addr_sel` output 1: 0 = PC, 1 = register operand (load/store address).
- `mem_we` output 1: store write enable; valid only with `mem_req`.
- `ir_we` output 1: latch fetched word into the instruction register.
- `pc_we` output 1: update PC.
- `pc_sel` output `PC_SEL_W`: 0 = PC+1, 1 = PC+sext(imm8), 2 = register value.
- `regfile_we` output 1: regfile write strobe.
- `wb_sel` output 1: 0 = ALU result, 1 = memory read data.
- `flags_we` output 1: flag register write strobe.
- `inst_retired` output 1: one-cycle pulse on the final cycle of each instruction.
- `state` output 3: current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- **FETCH**
  - If `halt`=1 on entry (no request yet outstanding), go to HALT with no `mem_req`.
  - Otherwise assert `mem_req`, `mem_addr_sel`=0, `mem_we`=0.
  - Hold until `mem_ready`. In that cycle pulse `ir_we` and go to DECODE.
  - Once `mem_req` has been issued, `halt` is ignored until the fetch completes.
- **DECODE**: one cycle for decoder and regfile read. Next state:
  - `inst_type`=1 or 2 → MEM.
  - Otherwise → EXECUTE.
- **EXECUTE**
  - `regfile_we`=`update_regfile`, `wb_sel`=0, `flags_we`=`update_flags`.
  - `pc_we`=1; `pc_sel`=0 if not taken, else (`pc_disp_abs` ? 2 : 1).
  - Pulse `inst_retired`, then go to FETCH.
- **MEM**
  - Assert `mem_req`, `mem_addr_sel`=1, `mem_we`=(`inst_type`==2).
  - Hold until `mem_ready`.
  - Store: on `mem_ready`, `pc_we`=1, `pc_sel`=0, `inst_retired`=1, go to FETCH.
  - Load: on `mem_ready`, go to WRITEBACK.
- **WRITEBACK**: `regfile_we`=1, `wb_sel`=1, `pc_we`=1, `pc_sel`=0, `inst_retired`=1, then go to FETCH.
- **HALT**: all strobes 0. Leave to FETCH in the first cycle `halt`=0.
- Condition evaluation (taken = 1):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C. 4 HI: L. 5 LS: !L. 6 GT: N. 7 LE: !N.
  - 8 FS: F. 9 FC: !F. 10 LO: !L&!Z. 11 HS: L|Z. 12 LT: !N&!Z. 13 GE: N|Z.
  - 14 UC: 1. 15: 0.
  - Non-branch instructions carry `cond`=15, so they fall through to PC+1 with no special case.
- `flags` are sampled in EXECUTE; this reflects all earlier instructions because execution is strictly sequential.
- `mem_ready` is ignored outside FETCH and MEM, and in any cycle with `mem_req`=0.

## Timing
- All outputs are combinational functions of `state` and inputs. `state` is registered.
- While `reset`=1: `state`←FETCH, and all outputs are forced to 0 (including `mem_req`). `state` reads 0.
- First `mem_req` appears in the first cycle with `reset`=0.
- Reset asserted mid-MEM or mid-FETCH aborts the access: no `pc_we`, `regfile_we` or `ir_we` in that cycle, and the next state is FETCH.
- `mem_req`, `mem_addr_sel` and `mem_we` stay stable from assertion until the `mem_ready` cycle.
- Minimum latency with zero-wait memory (`mem_ready` high in the request cycle):
  - ALU/branch: 3 cycles.
  - Store: 3 cycles.
  - Load: 4 cycles.
- Each cycle of `mem_ready`=0 adds one cycle.
- Exactly one `inst_retired` per instruction, in the same cycle as its `pc_we`.

## Test plan
- ADD, zero-wait memory, `update_regfile`=`update_flags`=1: states 0→1→2→0. In EXECUTE, `regfile_we`=`flags_we`=`pc_we`=1, `pc_sel`=0, `inst_retired`=1.
- Bcond with `cond`=0 and Z=1, `pc_disp_abs`=0 → `pc_sel`=1. Repeat with Z=0 → `pc_sel`=0. Jcond with `cond`=14, `pc_disp_abs`=1 → `pc_sel`=2.
- Load with `mem_ready` low for 2 cycles in MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=0 held for 3 cycles. WRITEBACK follows with `wb_sel`=1, `regfile_we`=1. Total 6 cycles.
- Store, zero-wait memory: MEM drives `mem_we`=1. On completion `pc_we`=1, `inst_retired`=1; `regfile_we`=0 throughout.
- `halt`=1 on FETCH entry → HALT, `mem_req`=0 for 5 cycles. `halt`=0 → FETCH next cycle. `halt` raised during a stalled fetch → fetch still completes into DECODE.
- `reset` pulsed during a stalled MEM → no strobes in that cycle, `state`=0 afterward, and a fresh fetch is issued.
